fnd_scan_decoder: RTL and testbench
===================================

# fnd_scan_decoder

Receive-side counterpart of the 4-digit multiplexed 7-segment driver. Samples the scanned `fnd_com`/`fnd_data` bus and decodes each active-low segment pattern back to BCD. Assembles one complete 4-digit frame and converts it to a binary count with a multi-cycle multiply-accumulate. Used as an on-chip self-check monitor and as a loopback receiver in board-level tests of the display path.

## Interface
- `MAX_COUNT`, 9_999, largest representable frame value.
- `WIDTH_COUNTER`, `$clog2(MAX_COUNT+1)` (14), width of `value`.
- `STABLE_CYCLES`, 4, consecutive identical synchronized samples required before a digit is captured (min 1).
- `clk` in 1: system clock.
- `rst` in 1: reset, asynchronous, active-high.
- `fnd_com` in 4: digit enables, active-low one-hot (`1110` = ones digit … `0111` = thousands digit).
- `fnd_data` in 8: segment lines, active-low; bit 7 = decimal point (ignored), bits 6:0 = g..a.
- `value` out WIDTH_COUNTER: binary value of the last good frame.
- `digits` out 16: BCD of the last good frame, `{d3,d2,d1,d0}`.
- `valid` out 1: one-cycle pulse when `value`/`digits` update.
- `err` out 1: one-cycle pulse when a frame is discarded (present only with `FND_SCAN_ERR_EN`, else tied 0).

## Operation
- Input sync: 2-FF synchronizer on `{fnd_com, fnd_data}`. Reset value of each stage is all-ones (inactive bus).
- Stability filter:
  - Counter increments while the synchronized sample equals the previous sample, and clears to 0 on any change.
  - Capture fires exactly once per stable run, on the cycle the counter reaches `STABLE_CYCLES-1`. A new run needs a change.
- Digit index from `fnd_com`: `1110`→0, `1101`→1, `1011`→2, `0111`→3. Any other pattern (`1111`, multi-low) → no capture, and the filter still runs.
- Segment decode on `fnd_data[6:0]`: `40`→0, `79`→1, `24`→2, `30`→3, `19`→4, `12`→5, `02`→6, `78`→7, `00`→8, `10`→9. Any other pattern is invalid.
- Capture writes the digit into collect slot[idx] and sets `seen[idx]`. A repeated index overwrites the slot.
- FSM states:
  - IDLE: waits for `seen==4'b1111`. On that, snapshot the 4 slots into conversion registers, clear `seen`, set acc=0 and step=3, then go to CONVERT.
  - CONVERT: each cycle acc ← acc*10 + d[step] and step decrements. After step 0, go to DONE.
  - DONE: `value`←acc, `digits`←snapshot, `valid`←1, then go to IDLE.
- Collection continues during CONVERT/DONE into the cleared `seen`/slots. A frame completing during CONVERT is held until IDLE.
- A capture that completes `seen` in the same cycle the FSM leaves IDLE is not lost: `seen` clear and the new set are merged with set priority.
- Arithmetic: acc is WIDTH_COUNTER bits. The max intermediate is 999*10+9 = 9999, so there is no overflow for legal BCD.

## Timing
- Input to capture: 2 sync cycles + `STABLE_CYCLES` cycles after the bus settles.
- Edge E0 registers `seen==1111`. E1 enters CONVERT. E2–E5 perform the four MAC steps. E6 is DONE: `valid` high for the cycle after E6.
- Minimum frame-to-`valid` latency: 6 clocks from `seen` completion.
- Reset values: `value`=0, `digits`=0, `valid`=0, `err`=0, `seen`=0, state=IDLE, stable counter=0.
- Reset mid-conversion: all of the above are forced immediately (asynchronous) and the partial result is discarded.

## Configuration
- `FND_SCAN_ERR_EN` defined:
  - An invalid segment pattern at capture clears `seen` and all slots, and pulses `err` for one cycle (the cycle after capture).
  - The in-flight CONVERT is unaffected.
- Not defined:
  - Invalid patterns are captured as digit 0 and `seen` is set normally.
  - `err` is constant 0 and the error logic is removed.

## Test plan
- Drive a stable scan of 1234 (each digit held 8 cycles, STABLE_CYCLES=4) → one `valid` pulse, `value`=1234, `digits`=16'h1234.
- Scan 9999, then 0000, back to back → two `valid` pulses with `value`=9999 then 0. No overflow.
- Glitch: insert a 2-cycle `fnd_data`=`7F` between digits → no capture of the glitch, result unchanged.
- `fnd_com`=`1111` for 20 cycles between digits, and `1100` for 10 cycles → no capture, frame completes normally on resumption.
- With `FND_SCAN_ERR_EN`, send pattern `7F` on digit 2 → `err` pulses once, no `valid` until a full new frame; `value` keeps its prior value.
- Assert `rst` during CONVERT of 5678 → `valid` never pulses, `value`=0, and the next full frame 0042 yields `value`=42.

Source files
------------

// File: rtl/fnd_scan_if.sv
// Scanned 7-segment display bus plus the decoded-frame results.
// The master side drives the scan (display driver or testbench);
// the slave side is the scan decoder that returns value/digits/valid/err.
interface fnd_scan_if #(
    parameter int WIDTH_COUNTER = 14
);
    logic [3:0]               fnd_com;
    logic [7:0]               fnd_data;
    logic [WIDTH_COUNTER-1:0] value;
    logic [15:0]              digits;
    logic                     valid;
    logic                     err;

    modport master (
        output fnd_com,
        output fnd_data,
        input  value,
        input  digits,
        input  valid,
        input  err
    );

    modport slave (
        input  fnd_com,
        input  fnd_data,
        output value,
        output digits,
        output valid,
        output err
    );
endinterface

// File: rtl/fnd_scan_decoder.sv
// Receive-side decoder for a 4-digit multiplexed, active-low 7-segment scan.
// Synchronizes the scan bus, captures each digit once its pattern has been
// stable long enough, assembles a full frame and converts it to binary with
// a four-step multiply-accumulate.
// Optional feature macro: FND_SCAN_ERR_EN -- when defined, an unknown segment
// pattern discards the frame being collected and pulses err; when undefined
// the unknown pattern is taken as digit 0 and err is tied low.
//
// state    | meaning
// ---------+---------------------------------------------------------------
// S_IDLE   | wait for all four digit slots to be seen, then snapshot them
// S_CONVERT| one MAC step per cycle, thousands digit first
// S_DONE   | publish value/digits and pulse valid
module fnd_scan_decoder #(
    parameter int MAX_COUNT     = 9_999,
    parameter int WIDTH_COUNTER = $clog2(MAX_COUNT + 1),
    parameter int STABLE_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst,
    fnd_scan_if.slave  bus
);

    localparam int CNT_W = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [11:0] BUS_IDLE = 12'hFFF;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_CONVERT = 2'd1,
        S_DONE    = 2'd2
    } state_t;

    // synchronizer and stability filter
    logic [11:0]      sync1_q, sync1_d;
    logic [11:0]      sync2_q, sync2_d;
    logic [11:0]      prev_q, prev_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             armed_q, armed_d;
    logic             cap_fire;

    // digit decode of the stable sample
    logic [1:0]       cap_idx;
    logic             idx_ok;
    logic [3:0]       seg_val;
    logic             seg_ok;
    logic             cap_en;

    // frame collection
    logic [3:0][3:0]  slot_q, slot_d;
    logic [3:0]       seen_q, seen_d;
    logic             frame_take;

    // conversion FSM and datapath
    state_t                   state_q, state_d;
    logic [15:0]              conv_q, conv_d;
    logic [WIDTH_COUNTER-1:0] acc_q, acc_d;
    logic [1:0]               step_q, step_d;
    logic [3:0]               conv_digit;
    logic [WIDTH_COUNTER-1:0] value_q, value_d;
    logic [15:0]              digits_q, digits_d;
    logic                     valid_q, valid_d;

`ifdef FND_SCAN_ERR_EN
    logic                     err_q, err_d;
`endif

    // The stable sample is prev_q: cnt_q counts how many consecutive
    // comparisons have matched it. A capture fires once per run; armed is
    // re-raised only by a bus change.
    assign cap_fire = armed_q && (cnt_q == CNT_LAST);

    // Synchronizer stages and the run-length counter for the filter
    always_comb begin
        sync1_d = {bus.fnd_com, bus.fnd_data};
        sync2_d = sync1_q;
        prev_d  = sync2_q;
        cnt_d   = cnt_q;
        armed_d = armed_q;
        if (sync2_q != prev_q) begin
            cnt_d   = '0;
            armed_d = 1'b1;
        end else begin
            if (cnt_q != CNT_LAST) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
            if (cap_fire) begin
                armed_d = 1'b0;
            end
        end
    end

    // Register the synchronizer and filter state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= BUS_IDLE;
            sync2_q <= BUS_IDLE;
            prev_q  <= BUS_IDLE;
            cnt_q   <= '0;
            armed_q <= 1'b0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            prev_q  <= prev_d;
            cnt_q   <= cnt_d;
            armed_q <= armed_d;
        end
    end

    // Digit enable to slot index; blank or multi-low patterns never capture
    always_comb begin
        cap_idx = 2'd0;
        idx_ok  = 1'b1;
        case (prev_q[11:8])
            4'b1110: cap_idx = 2'd0;
            4'b1101: cap_idx = 2'd1;
            4'b1011: cap_idx = 2'd2;
            4'b0111: cap_idx = 2'd3;
            default: idx_ok  = 1'b0;
        endcase
    end

    // Active-low segment pattern (g..a) to BCD; the decimal point is ignored
    always_comb begin
        seg_val = 4'd0;
        seg_ok  = 1'b1;
        case (prev_q[6:0])
            7'h40:   seg_val = 4'd0;
            7'h79:   seg_val = 4'd1;
            7'h24:   seg_val = 4'd2;
            7'h30:   seg_val = 4'd3;
            7'h19:   seg_val = 4'd4;
            7'h12:   seg_val = 4'd5;
            7'h02:   seg_val = 4'd6;
            7'h78:   seg_val = 4'd7;
            7'h00:   seg_val = 4'd8;
            7'h10:   seg_val = 4'd9;
            default: seg_ok  = 1'b0;
        endcase
    end

    assign cap_en     = cap_fire && idx_ok;
    assign frame_take = (state_q == S_IDLE) && (seen_q == 4'b1111);

    // Collect digits into slots; a capture landing on the cycle the FSM
    // takes the frame wins over the clear so it starts the next frame.
    always_comb begin
        slot_d = slot_q;
        seen_d = seen_q;
`ifdef FND_SCAN_ERR_EN
        err_d  = 1'b0;
`endif
        if (frame_take) begin
            seen_d = 4'b0000;
        end
        if (cap_en) begin
`ifdef FND_SCAN_ERR_EN
            if (seg_ok) begin
                slot_d[cap_idx] = seg_val;
                seen_d[cap_idx] = 1'b1;
            end else begin
                slot_d = '0;
                seen_d = 4'b0000;
                err_d  = 1'b1;
            end
`else
            slot_d[cap_idx] = seg_ok ? seg_val : 4'd0;
            seen_d[cap_idx] = 1'b1;
`endif
        end
    end

    // Register collected slots, seen mask and the error pulse
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            slot_q <= '0;
            seen_q <= 4'b0000;
`ifdef FND_SCAN_ERR_EN
            err_q  <= 1'b0;
`endif
        end else begin
            slot_q <= slot_d;
            seen_q <= seen_d;
`ifdef FND_SCAN_ERR_EN
            err_q  <= err_d;
`endif
        end
    end

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (seen_q == 4'b1111) begin
                    state_d = S_CONVERT;
                end
            end
            S_CONVERT: begin
                if (step_q == 2'd0) begin
                    state_d = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    assign conv_digit = conv_q[{step_q, 2'b00} +: 4];

    // FSM outputs: snapshot, MAC steps and result publication.
    // acc never exceeds 999*10+9 for legal BCD, so WIDTH_COUNTER bits suffice.
    always_comb begin
        conv_d   = conv_q;
        acc_d    = acc_q;
        step_d   = step_q;
        value_d  = value_q;
        digits_d = digits_q;
        valid_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (frame_take) begin
                    conv_d = slot_q;
                    acc_d  = '0;
                    step_d = 2'd3;
                end
            end
            S_CONVERT: begin
                acc_d  = acc_q * WIDTH_COUNTER'(10) + WIDTH_COUNTER'(conv_digit);
                step_d = step_q - 2'd1;
            end
            S_DONE: begin
                value_d  = acc_q;
                digits_d = conv_q;
                valid_d  = 1'b1;
            end
            default: ;
        endcase
    end

    // Register conversion datapath and published results
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            conv_q   <= '0;
            acc_q    <= '0;
            step_q   <= 2'd0;
            value_q  <= '0;
            digits_q <= '0;
            valid_q  <= 1'b0;
        end else begin
            conv_q   <= conv_d;
            acc_q    <= acc_d;
            step_q   <= step_d;
            value_q  <= value_d;
            digits_q <= digits_d;
            valid_q  <= valid_d;
        end
    end

    assign bus.value  = value_q;
    assign bus.digits = digits_q;
    assign bus.valid  = valid_q;
`ifdef FND_SCAN_ERR_EN
    assign bus.err    = err_q;
`else
    assign bus.err    = 1'b0;
`endif

endmodule

// File: tb/tb_fnd_scan_decoder.sv
// Directed bench for fnd_scan_decoder: scans whole frames onto the bus and
// compares the decoded results against hand-computed values.
module tb_fnd_scan_decoder;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    fnd_scan_if #(.WIDTH_COUNTER(14)) bus ();

    fnd_scan_decoder #(
        .MAX_COUNT     (9_999),
        .WIDTH_COUNTER (14),
        .STABLE_CYCLES (4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;
    int err_cnt  = 0;
    int last_chg = 0;
    logic [13:0] v_val[$];
    logic [15:0] v_dig[$];
    int          v_cyc[$];

    // free-running cycle count for latency measurement
    always @(posedge clk) cyc <= cyc + 1;

    // record every valid and err pulse away from the active edge
    always @(negedge clk) begin
        if (bus.valid === 1'b1) begin
            v_val.push_back(bus.value);
            v_dig.push_back(bus.digits);
            v_cyc.push_back(cyc);
        end
        if (bus.err === 1'b1) err_cnt <= err_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp, exp);
        end
    endtask

    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'd0: seg7 = 7'h40;
            4'd1: seg7 = 7'h79;
            4'd2: seg7 = 7'h24;
            4'd3: seg7 = 7'h30;
            4'd4: seg7 = 7'h19;
            4'd5: seg7 = 7'h12;
            4'd6: seg7 = 7'h02;
            4'd7: seg7 = 7'h78;
            4'd8: seg7 = 7'h00;
            4'd9: seg7 = 7'h10;
            default: seg7 = 7'h7F;
        endcase
    endfunction

    function automatic logic [3:0] com_of(input int i);
        logic [3:0] one;
        one = 4'b0001;
        com_of = ~(one << i);
    endfunction

    // called just after a rising edge; holds the pattern for n cycles
    task automatic drive(input logic [3:0] com, input logic [7:0] data, input int n);
        bus.fnd_com  = com;
        bus.fnd_data = data;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drive_digit(input int i, input logic [3:0] d, input logic dp_on, input int n);
        if (i == 3) last_chg = cyc;
        drive(com_of(i), {~dp_on, seg7(d)}, n);
    endtask

    task automatic send_frame(input logic [15:0] bcd, input logic [3:0] dp_mask);
        for (int i = 0; i < 4; i++) begin
            drive_digit(i, bcd[4*i +: 4], dp_mask[i], 8);
        end
    endtask

    task automatic wait_frames(input int target, input int budget, input string tag);
        for (int k = 0; k < budget && v_val.size() < target; k++) begin
            @(posedge clk);
            #1;
        end
        chk(tag, v_val.size(), target);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.fnd_com  = 4'b1111;
        bus.fnd_data = 8'hFF;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_value",  bus.value,  0);
        chk("rst_digits", bus.digits, 0);
        chk("rst_valid",  bus.valid,  0);
        chk("rst_err",    bus.err,    0);
        rst = 1'b0;
        repeat (2) begin @(posedge clk); #1; end

        // plain frame 1234, decimal point lit on digit 1
        send_frame(16'h1234, 4'b0010);
        drive(4'b1111, 8'hFF, 1);
        wait_frames(1, 40, "f1234_count");
        chk("f1234_value",  v_val[0], 1234);
        chk("f1234_digits", v_dig[0], 16'h1234);
        chk("f1234_latency_ok", (v_cyc[0] - last_chg >= 11) && (v_cyc[0] - last_chg <= 15), 1);
        repeat (20) begin @(posedge clk); #1; end
        chk("f1234_single_pulse", v_val.size(), 1);
        chk("f1234_hold_value", bus.value, 1234);

        // back-to-back 9999 then 0000
        send_frame(16'h9999, 4'b0000);
        send_frame(16'h0000, 4'b0000);
        drive(4'b1111, 8'hFF, 1);
        wait_frames(3, 40, "b2b_count");
        chk("b2b_first",        v_val[1], 9999);
        chk("b2b_first_digits", v_dig[1], 16'h9999);
        chk("b2b_second",       v_val[2], 0);
        chk("b2b_second_digits", v_dig[2], 16'h0000);

        // 2-cycle blank glitch on the ones digit after it was captured
        drive_digit(0, 4'd1, 1'b0, 8);
        drive(4'b1110, 8'h7F, 2);
        drive_digit(1, 4'd2, 1'b0, 8);
        drive_digit(2, 4'd3, 1'b0, 8);
        drive_digit(3, 4'd4, 1'b0, 8);
        drive(4'b1111, 8'hFF, 1);
        wait_frames(4, 40, "glitch_count");
        chk("glitch_value",  v_val[3], 4321);
        chk("glitch_digits", v_dig[3], 16'h4321);

        // blank enables and a multi-low enable between digits
        drive_digit(0, 4'd7, 1'b0, 8);
        drive(4'b1111, 8'hFF, 20);
        drive_digit(1, 4'd0, 1'b0, 8);
        drive(4'b1100, {1'b1, seg7(4'd5)}, 10);
        drive_digit(2, 4'd9, 1'b0, 8);
        drive_digit(3, 4'd0, 1'b0, 8);
        drive(4'b1111, 8'hFF, 1);
        wait_frames(5, 40, "blank_count");
        chk("blank_value",  v_val[4], 907);
        chk("blank_digits", v_dig[4], 16'h0907);
        chk("no_err_so_far", err_cnt, 0);

        // unknown segment pattern on digit 2
        drive_digit(0, 4'd5, 1'b0, 8);
        drive_digit(1, 4'd6, 1'b0, 8);
        drive(com_of(2), 8'h7F, 8);
        drive_digit(3, 4'd8, 1'b0, 8);
        drive(4'b1111, 8'hFF, 1);
`ifdef FND_SCAN_ERR_EN
        repeat (30) begin @(posedge clk); #1; end
        chk("bad_err_pulses", err_cnt, 1);
        chk("bad_no_valid",   v_val.size(), 5);
        chk("bad_value_kept", bus.value, 907);
`else
        wait_frames(6, 40, "bad_count");
        chk("bad_as_zero_value",  v_val[5], 8065);
        chk("bad_as_zero_digits", v_dig[5], 16'h8065);
        chk("bad_err_low", err_cnt, 0);
`endif
        send_frame(16'h1357, 4'b0000);
        drive(4'b1111, 8'hFF, 1);
`ifdef FND_SCAN_ERR_EN
        wait_frames(6, 40, "after_bad_count");
        chk("after_bad_value", v_val[5], 1357);
`else
        wait_frames(7, 40, "after_bad_count");
        chk("after_bad_value", v_val[6], 1357);
`endif
        chk("after_bad_bus_value", bus.value, 1357);

        // reset while 5678 is being converted
        begin
            int n_before;
            n_before = v_val.size();
            drive_digit(0, 4'd8, 1'b0, 8);
            drive_digit(1, 4'd7, 1'b0, 8);
            drive_digit(2, 4'd6, 1'b0, 8);
            drive_digit(3, 4'd5, 1'b0, 10);
            bus.fnd_com  = 4'b1111;
            bus.fnd_data = 8'hFF;
            rst = 1'b1;
            #1;
            chk("rstmid_value", bus.value, 0);
            chk("rstmid_valid", bus.valid, 0);
            repeat (3) begin @(posedge clk); #1; end
            rst = 1'b0;
            repeat (30) begin @(posedge clk); #1; end
            chk("rstmid_no_valid", v_val.size(), n_before);
            chk("rstmid_value_after", bus.value, 0);
            send_frame(16'h0042, 4'b0000);
            drive(4'b1111, 8'hFF, 1);
            wait_frames(n_before + 1, 40, "f0042_count");
            chk("f0042_value",  v_val[n_before], 42);
            chk("f0042_digits", v_dig[n_before], 16'h0042);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
